// File: rtl/nand_flash_clk_rst_seq_pkg.sv
// Shared definitions for the fabric clock/reset sequencer.
//   seq_state_e  : sequencer state encoding, also driven out on SEQ_STATE
//   SEQ_STATE_W  : width of the debug state output
//   LOSS_CNT_W   : width of the saturating lock-loss counter
//   sat_inc      : saturating increment used for the lock-loss counter
package nand_flash_clk_pkg;

  localparam int SEQ_STATE_W = 3;
  localparam int LOSS_CNT_W  = 8;

  typedef enum logic [SEQ_STATE_W-1:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FLUSH     = 3'd4
  } seq_state_e;

  // Holds at all ones instead of wrapping.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/nand_flash_lock_sync.sv
// Generic two-flop level synchronizer with synchronous reset to 0.
//   clk   : destination clock
//   reset : synchronous, active-high; clears both flops
//   d     : asynchronous level input
//   q     : synchronized level, two clk cycles after d
module nand_flash_lock_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nand_flash_clk_rst_seq.sv
// Clock/reset sequencer for the fabric clock domain. Waits for CCC lock and
// system init, requires lock to stay up for LOCK_STABLE_CYCLES, then releases
// the stage resets one at a time (bit 0 = PHY/IO, then controller core, then
// host interface) with STAGE_GAP_CYCLES between releases. Lock loss or a soft
// reset request re-asserts every reset and re-sequences.
//   CLK           : fabric clock
//   RESET         : synchronous, active-high; highest priority
//   CCC_LOCK      : CCC lock, asynchronous, synchronized internally
//   INIT_DONE     : system init complete, synchronous level
//   SOFT_RST_REQ  : one-cycle pulse requesting a full re-sequence; no
//                   handshake, the pulse is acted on in the cycle it is seen
//                   (STABLE/RELEASE/RUN) and dropped in any other state
//   RST_OUT       : active-high stage resets, registered
//   ALL_READY     : registered, high while in RUN
//   SEQ_STATE     : current state (seq_state_e), for debug
//   TIMEOUT_ERR   : sticky lock-timeout flag, cleared only by RESET
//   LOCK_LOSS_CNT : saturating count of lock losses during RELEASE/RUN
module nand_flash_clk_rst_seq
  import nand_flash_clk_pkg::*;
#(
  parameter int NUM_STAGES          = 3,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP_CYCLES    = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int CNT_W               = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CCC_LOCK,
  input  logic                   INIT_DONE,
  input  logic                   SOFT_RST_REQ,
  output logic [NUM_STAGES-1:0]  RST_OUT,
  output logic                   ALL_READY,
  output logic [SEQ_STATE_W-1:0] SEQ_STATE,
  output logic                   TIMEOUT_ERR,
  output logic [LOSS_CNT_W-1:0]  LOCK_LOSS_CNT
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_STAGES - 1);

  logic lock_s;
  logic lock_ok;

  seq_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;

  nand_flash_lock_sync u_lock_sync (
    .clk   (CLK),
    .reset (RESET),
    .d     (CCC_LOCK),
    .q     (lock_s)
  );

  assign lock_ok = lock_s & INIT_DONE;

  // State register (all sequencer state, including the registered outputs).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    loss_d  = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        // The counter parks at the timeout value so the flag stays meaningful
        // while lock remains absent.
        if (cnt_q == TIMEOUT_LAST) err_d = 1'b1;
        else                       cnt_d = cnt_q + CNT_W'(1);
        if (lock_ok) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        // A drop here is a debounce failure, not a lock loss.
        if (!lock_ok) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (SOFT_RST_REQ) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = FLUSH;
          cnt_d   = '0;
          loss_d  = sat_inc(loss_q);
        end else if (SOFT_RST_REQ) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = RUN;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = FLUSH;
          cnt_d   = '0;
          loss_d  = sat_inc(loss_q);
        end else if (SOFT_RST_REQ) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (cnt_q == GAP_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: computed from the next state so the outputs are registered
  // on the same edge as the transition that changes them.
  always_comb begin
    rst_d   = '1;
    ready_d = 1'b0;
    case (state_d)
      RELEASE: begin
        // Bits only ever clear in RELEASE; idx_d names the bit released now.
        for (int k = 0; k < NUM_STAGES; k++) begin
          rst_d[k] = rst_q[k] & (idx_d != IDX_W'(k));
        end
      end
      RUN: begin
        rst_d   = '0;
        ready_d = 1'b1;
      end
      default: begin
        rst_d   = '1;
        ready_d = 1'b0;
      end
    endcase
  end

  assign RST_OUT       = rst_q;
  assign ALL_READY     = ready_q;
  assign SEQ_STATE     = state_q;
  assign TIMEOUT_ERR   = err_q;
  assign LOCK_LOSS_CNT = loss_q;

endmodule
